// File: rtl/camera_capture.sv
// Parallel camera receiver: oversamples pclk/vsync/href/data in the clk domain,
// pairs bytes into RGB565 pixels and tags them with x/y and a linear buffer address.
module camera_capture #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_en,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic [15:0]       pix_data,
    output logic              pix_valid,
    output logic [9:0]        pix_x,
    output logic [8:0]        pix_y,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              frame_start,
    output logic              frame_done,
    output logic              err_odd,
    output logic              err_ovf
);

    localparam logic [1:0] ST_SYNC   = 2'd0;
    localparam logic [1:0] ST_VBLANK = 2'd1;
    localparam logic [1:0] ST_SKIP   = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

    localparam logic [10:0]       W_LIM  = 11'(WIDTH);
    localparam logic [9:0]        H_LIM  = 10'(HEIGHT);
    localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(WIDTH);

    logic              r_pclk_m, r_pclk_s, r_pclk_d;
    logic              r_vsync_m, r_vsync_s;
    logic              r_href_m, r_href_s, r_href_prev;
    logic [7:0]        r_data_m, r_data_s;
    logic [1:0]        r_state;
    logic              r_phase;
    logic [7:0]        r_hi;
    logic [10:0]       r_x;
    logic [9:0]        r_y;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_base;
    logic              r_line_pix;
    logic              w_edge;

    assign w_edge = r_pclk_s & ~r_pclk_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pclk_m    <= 1'b0;
            r_pclk_s    <= 1'b0;
            r_pclk_d    <= 1'b0;
            r_vsync_m   <= 1'b0;
            r_vsync_s   <= 1'b0;
            r_href_m    <= 1'b0;
            r_href_s    <= 1'b0;
            r_href_prev <= 1'b0;
            r_data_m    <= '0;
            r_data_s    <= '0;
            r_state     <= ST_SYNC;
            r_phase     <= 1'b0;
            r_hi        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_addr      <= '0;
            r_base      <= '0;
            r_line_pix  <= 1'b0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_addr    <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err_odd     <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            r_pclk_m  <= cam_pclk;
            r_pclk_s  <= r_pclk_m;
            r_pclk_d  <= r_pclk_s;
            r_vsync_m <= cam_vsync;
            r_vsync_s <= r_vsync_m;
            r_href_m  <= cam_href;
            r_href_s  <= r_href_m;
            r_data_m  <= cam_data;
            r_data_s  <= r_data_m;

            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;

            if (w_edge) begin
                r_href_prev <= r_href_s;
                case (r_state)
                    ST_SYNC: begin
                        if (r_vsync_s) r_state <= ST_VBLANK;
                    end
                    ST_VBLANK: begin
                        if (!r_vsync_s) begin
                            if (capture_en) begin
                                r_state     <= ST_ACTIVE;
                                frame_start <= 1'b1;
                                err_odd     <= 1'b0;
                                err_ovf     <= 1'b0;
                                r_x         <= '0;
                                r_y         <= '0;
                                r_addr      <= '0;
                                r_base      <= '0;
                                r_phase     <= 1'b0;
                                r_line_pix  <= 1'b0;
                            end else begin
                                r_state <= ST_SKIP;
                            end
                        end
                    end
                    ST_SKIP: begin
                        if (r_vsync_s) r_state <= ST_VBLANK;
                    end
                    ST_ACTIVE: begin
                        if (r_href_s) begin
                            if (!r_phase) begin
                                r_hi    <= r_data_s;
                                r_phase <= 1'b1;
                            end else begin
                                r_phase <= 1'b0;
                                if (r_x < W_LIM && r_y < H_LIM) begin
                                    pix_valid  <= 1'b1;
                                    pix_data   <= {r_hi, r_data_s};
                                    pix_x      <= r_x[9:0];
                                    pix_y      <= r_y[8:0];
                                    pix_addr   <= r_addr;
                                    r_x        <= r_x + 11'd1;
                                    r_addr     <= r_addr + 1'b1;
                                    r_line_pix <= 1'b1;
                                end else begin
                                    err_ovf <= 1'b1;
                                end
                            end
                        end else if (r_href_prev) begin
                            // Short lines leave a gap: the next line always starts at y*WIDTH.
                            if (r_phase) err_odd <= 1'b1;
                            r_phase    <= 1'b0;
                            r_x        <= '0;
                            r_line_pix <= 1'b0;
                            if (r_line_pix && r_y < H_LIM) begin
                                r_y    <= r_y + 10'd1;
                                r_base <= r_base + W_STEP;
                                r_addr <= r_base + W_STEP;
                            end else begin
                                r_addr <= r_base;
                            end
                        end
                        // Any byte on this tick is handled above before the frame closes.
                        if (r_vsync_s) begin
                            r_state    <= ST_VBLANK;
                            frame_done <= 1'b1;
                        end
                    end
                    default: r_state <= ST_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// Scoreboard bench for camera_capture: drives a small-geometry camera stream and
// checks every emitted pixel plus frame markers and error flags.
module tb_camera_capture;

    localparam int W  = 16;
    localparam int H  = 6;
    localparam int AW = 19;

    typedef struct packed {
        logic [15:0]   d;
        logic [9:0]    x;
        logic [8:0]    y;
        logic [AW-1:0] a;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          capture_en;
    logic          cam_pclk;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;
    logic [15:0]   pix_data;
    logic          pix_valid;
    logic [9:0]    pix_x;
    logic [8:0]    pix_y;
    logic [AW-1:0] pix_addr;
    logic          frame_start;
    logic          frame_done;
    logic          err_odd;
    logic          err_ovf;

    pix_t          exp_q[$];
    logic [7:0]    pat [5] = '{8'hAA, 8'h0B, 8'hAC, 8'h0D, 8'hAE};
    int            n_asserts = 0;
    int            n_fail = 0;
    int            n_pix = 0;
    int            n_fs = 0;
    int            n_fd = 0;
    logic [AW-1:0] last_addr = '0;
    bit            both_seen = 0;
    logic          prev_valid = 1'b0;

    camera_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .capture_en(capture_en),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_addr(pix_addr), .frame_start(frame_start), .frame_done(frame_done),
        .err_odd(err_odd), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: one line per received pixel.
    always @(negedge clk) begin
        pix_t e;
        if (pix_valid) begin
            n_pix++;
            last_addr = pix_addr;
            n_asserts++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pixel: got data=%h x=%0d y=%0d addr=%0d, expected none",
                         pix_data, pix_x, pix_y, pix_addr);
            end else begin
                e = exp_q.pop_front();
                if ({pix_data, pix_x, pix_y, pix_addr} !== e) begin
                    n_fail++;
                    $display("FAIL pixel: got data=%h x=%0d y=%0d addr=%0d, expected data=%h x=%0d y=%0d addr=%0d",
                             pix_data, pix_x, pix_y, pix_addr, e.d, e.x, e.y, e.a);
                end else begin
                    $display("pixel data=%h x=%0d y=%0d addr=%0d ok", pix_data, pix_x, pix_y, pix_addr);
                end
            end
            if (frame_done) both_seen = 1;
        end
        if (pix_valid && prev_valid) begin
            n_asserts++;
            n_fail++;
            $display("FAIL pix_valid_width: got two consecutive high clks, expected single-clk strobe");
        end
        prev_valid = pix_valid;
        if (frame_start) n_fs++;
        if (frame_done) n_fd++;
    end

    task automatic cam_byte(input logic [7:0] d, input logic h, input logic v);
        @(negedge clk);
        cam_data  = d;
        cam_href  = h;
        cam_vsync = v;
        repeat (2) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (2) @(negedge clk);
        cam_pclk = 1'b0;
    endtask

    // Drives one frame and pushes the pixels a correct receiver must emit.
    task automatic send_frame(input int nlines, input int nbytes, input int len0,
                              input bit cap, input bit vsync_last, input bit raise_en);
        int my;
        int p;
        int len;
        int emitted;
        bit last;
        pix_t e;
        my = 0;
        repeat (2) cam_byte(8'h00, 1'b0, 1'b1);
        cam_byte(8'h00, 1'b0, 1'b0);
        for (int l = 0; l < nlines; l++) begin
            emitted = 0;
            len = (l == 0) ? len0 : nbytes;
            if (raise_en && l == 1) capture_en = 1'b1;
            for (int i = 0; i < len; i++) begin
                last = (l == nlines - 1) && (i == len - 1);
                if (i % 2 == 1) begin
                    p = i / 2;
                    if (cap && my < H && p < W) begin
                        e.d = {pat[(2 * p) % 5], pat[(2 * p + 1) % 5]};
                        e.x = 10'(p);
                        e.y = 9'(my);
                        e.a = AW'(my * W + p);
                        exp_q.push_back(e);
                        emitted++;
                    end
                end
                cam_byte(pat[i % 5], 1'b1, vsync_last && last);
            end
            if (emitted > 0) my++;
            if (!(vsync_last && l == nlines - 1)) repeat (2) cam_byte(8'h00, 1'b0, 1'b0);
        end
        if (!vsync_last) cam_byte(8'h00, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        capture_en = 1'b1;
        cam_pclk = 1'b0;
        cam_vsync = 1'b0;
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (4) @(negedge clk);
        n_asserts++;
        if ({pix_valid, frame_start, frame_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b, expected 000", {pix_valid, frame_start, frame_done});
        end
        n_asserts++;
        if ({err_odd, err_ovf} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_errors: got %b, expected 00", {err_odd, err_ovf});
        end
        n_asserts++;
        if ({pix_data, pix_x, pix_y, pix_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got data=%h x=%0d y=%0d addr=%0d, expected all 0",
                     pix_data, pix_x, pix_y, pix_addr);
        end
        $display("test_reset done");
    endtask

    task automatic test_mid_reset();
        int pix0;
        int fs0;
        pix0 = n_pix;
        fs0 = n_fs;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) cam_byte(pat[i % 5], 1'b1, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cam_byte(pat[i % 5], 1'b1, 1'b0);
        repeat (2) cam_byte(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cam_byte(pat[i % 5], 1'b1, 1'b0);
        repeat (2) cam_byte(8'h00, 1'b0, 1'b0);
        n_asserts++;
        if (n_pix - pix0 != 0 || n_fs - fs0 != 0) begin
            n_fail++;
            $display("FAIL mid_reset_silent: got %0d pixels %0d frame_starts, expected 0 0", n_pix - pix0, n_fs - fs0);
        end
        send_frame(2, W, W, 1, 0, 0);
        n_asserts++;
        if (exp_q.size() != 0 || n_fs - fs0 != 1) begin
            n_fail++;
            $display("FAIL mid_reset_frame: got %0d pending %0d frame_starts, expected 0 1", exp_q.size(), n_fs - fs0);
        end
        $display("test_mid_reset done");
    endtask

    task automatic test_pattern();
        int pix0;
        pix0 = n_pix;
        send_frame(3, W, W, 1, 0, 0);
        n_asserts++;
        if (n_pix - pix0 != 3 * W / 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pattern_count: got %0d pixels %0d pending, expected %0d 0", n_pix - pix0, exp_q.size(), 3 * W / 2);
        end
        n_asserts++;
        if ({err_odd, err_ovf} !== 2'b00) begin
            n_fail++;
            $display("FAIL pattern_errors: got %b, expected 00", {err_odd, err_ovf});
        end
        $display("test_pattern done");
    endtask

    task automatic test_full_frame();
        int pix0;
        int fs0;
        int fd0;
        pix0 = n_pix;
        fs0 = n_fs;
        fd0 = n_fd;
        send_frame(H, 2 * W, 2 * W, 1, 0, 0);
        n_asserts++;
        if (n_pix - pix0 != W * H || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_count: got %0d pixels, expected %0d", n_pix - pix0, W * H);
        end
        n_asserts++;
        if (last_addr !== AW'(W * H - 1)) begin
            n_fail++;
            $display("FAIL full_last_addr: got %0d, expected %0d", last_addr, W * H - 1);
        end
        n_asserts++;
        if (n_fs - fs0 != 1 || n_fd - fd0 != 1) begin
            n_fail++;
            $display("FAIL full_markers: got fs=%0d fd=%0d, expected 1 1", n_fs - fs0, n_fd - fd0);
        end
        n_asserts++;
        if ({err_odd, err_ovf} !== 2'b00) begin
            n_fail++;
            $display("FAIL full_errors: got %b, expected 00", {err_odd, err_ovf});
        end
        $display("test_full_frame done");
    endtask

    task automatic test_odd_line();
        send_frame(2, 4, 3, 1, 0, 0);
        n_asserts++;
        if (err_odd !== 1'b1 || err_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_flags: got odd=%b ovf=%b, expected 1 0", err_odd, err_ovf);
        end
        n_asserts++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL odd_pending: got %0d, expected 0", exp_q.size());
        end
        $display("test_odd_line done");
    endtask

    task automatic test_overflow();
        int pix0;
        pix0 = n_pix;
        send_frame(1, 2 * W + 2, 2 * W + 2, 1, 0, 0);
        n_asserts++;
        if (err_ovf !== 1'b1 || err_odd !== 1'b0 || n_pix - pix0 != W) begin
            n_fail++;
            $display("FAIL ovf_line: got ovf=%b odd=%b pixels=%0d, expected 1 0 %0d", err_ovf, err_odd, n_pix - pix0, W);
        end
        send_frame(1, W, W, 1, 0, 0);
        n_asserts++;
        if (err_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b, expected 0", err_ovf);
        end
        pix0 = n_pix;
        send_frame(H + 1, 2 * W, 2 * W, 1, 0, 0);
        n_asserts++;
        if (err_ovf !== 1'b1 || n_pix - pix0 != W * H || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ovf_lines: got ovf=%b pixels=%0d, expected 1 %0d", err_ovf, n_pix - pix0, W * H);
        end
        $display("test_overflow done");
    endtask

    task automatic test_capture_disable();
        int pix0;
        int fs0;
        int fd0;
        pix0 = n_pix;
        fs0 = n_fs;
        fd0 = n_fd;
        capture_en = 1'b0;
        send_frame(3, W, W, 0, 0, 1);
        n_asserts++;
        if (n_pix - pix0 != 0 || n_fs - fs0 != 0 || n_fd - fd0 != 0) begin
            n_fail++;
            $display("FAIL disable_silent: got pix=%0d fs=%0d fd=%0d, expected 0 0 0", n_pix - pix0, n_fs - fs0, n_fd - fd0);
        end
        send_frame(1, W, W, 1, 0, 0);
        n_asserts++;
        if (n_fs - fs0 != 1 || n_pix - pix0 != W / 2) begin
            n_fail++;
            $display("FAIL disable_resume: got fs=%0d pix=%0d, expected 1 %0d", n_fs - fs0, n_pix - pix0, W / 2);
        end
        $display("test_capture_disable done");
    endtask

    task automatic test_back_to_back();
        int fd0;
        int fs0;
        fd0 = n_fd;
        fs0 = n_fs;
        both_seen = 0;
        send_frame(2, W, W, 1, 1, 0);
        send_frame(2, W, W, 1, 0, 0);
        n_asserts++;
        if (exp_q.size() != 0 || n_fd - fd0 != 2 || n_fs - fs0 != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: got pending=%0d fd=%0d fs=%0d, expected 0 2 2", exp_q.size(), n_fd - fd0, n_fs - fs0);
        end
        n_asserts++;
        if (both_seen != 1) begin
            n_fail++;
            $display("FAIL b2b_same_clk: got %0d, expected pix_valid and frame_done together (1)", both_seen);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_mid_reset();
        test_pattern();
        test_full_frame();
        test_odd_line();
        test_overflow();
        test_capture_disable();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
